// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32I-subset control sequencer:
// state codes, supported opcodes, immediate/ALU selects and the control bundle.
package ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        FETCH  = ST_FETCH,
        DECODE = ST_DECODE,
        EXEC   = ST_EXEC,
        MEM    = ST_MEM,
        WB     = ST_WB,
        HALT   = ST_HALT
    } state_t;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;

    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] imm_src;
        logic       pc_src;
        logic       mem_write;
        logic       result_src;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle sequencer for addi/bne/sw/lw: steps FETCH/DECODE/EXEC/MEM/WB,
// traps unknown opcodes into HALT and counts retired instructions.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 7,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] instr,
    input  logic             EQ,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [2:0]       ALUctrl,
    output logic             ALUsrc,
    output logic [2:0]       ImmSrc,
    output logic             PCsrc,
    output logic             MemWrite,
    output logic             ResultSrc,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [OPC_W-1:0] L_ADDI = OPC_W'(OP_ADDI);
    localparam logic [OPC_W-1:0] L_BNE  = OPC_W'(OP_BNE);
    localparam logic [OPC_W-1:0] L_SW   = OPC_W'(OP_SW);
    localparam logic [OPC_W-1:0] L_LW   = OPC_W'(OP_LW);

    state_t             state_q, state_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               halted_q, halted_d;
    logic               retire;
    ctrl_t              c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            op_q      <= '0;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        halted_d = halted_q;
        retire   = 1'b0;
        c        = '0;
        c.halted = halted_q;

        unique case (state_q)
            FETCH: begin
                c.imem_req = 1'b1;
                if (imem_ready) begin
                    c.ir_write = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                op_d = instr;
                if (instr == L_ADDI || instr == L_BNE || instr == L_SW || instr == L_LW) begin
                    state_d = EXEC;
                end else begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
            end
            EXEC: begin
                c.alu_ctrl = ALU_ADD;
                if (op_q == L_BNE) begin
                    // Branch resolves on the live ALU flag, so PC selection is Mealy here.
                    c.imm_src  = IMM_B;
                    c.pc_write = 1'b1;
                    c.pc_src   = ~EQ;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end else if (op_q == L_ADDI) begin
                    c.alu_src = 1'b1;
                    c.imm_src = IMM_I;
                    state_d   = WB;
                end else if (op_q == L_SW) begin
                    c.alu_src = 1'b1;
                    c.imm_src = IMM_S;
                    state_d   = MEM;
                end else begin
                    c.alu_src = 1'b1;
                    c.imm_src = IMM_I;
                    state_d   = MEM;
                end
            end
            MEM: begin
                c.dmem_req  = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = (op_q == L_SW) ? IMM_S : IMM_I;
                c.mem_write = (op_q == L_SW);
                if (dmem_ready) begin
                    if (op_q == L_SW) begin
                        c.pc_write = 1'b1;
                        retire     = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                c.reg_write  = 1'b1;
                c.result_src = (op_q == L_LW);
                c.pc_write   = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        instret_d = instret_q + CNT_W'(retire);

        // Reset is asynchronous: force every control low while rst_n is held.
        if (!rst_n) begin
            c = '0;
        end
    end

    assign imem_req  = c.imem_req;
    assign dmem_req  = c.dmem_req;
    assign IRWrite   = c.ir_write;
    assign PCWrite   = c.pc_write;
    assign RegWrite  = c.reg_write;
    assign ALUctrl   = c.alu_ctrl;
    assign ALUsrc    = c.alu_src;
    assign ImmSrc    = c.imm_src;
    assign PCsrc     = c.pc_src;
    assign MemWrite  = c.mem_write;
    assign ResultSrc = c.result_src;
    assign halted    = c.halted;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: cycle table, directed corner sequences and
// randomized instructions checked per instruction against a latency/effect model.
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int CW = 8;

    localparam logic [9:0] F_IREQ  = 10'b10_0000_0000;
    localparam logic [9:0] F_DREQ  = 10'b01_0000_0000;
    localparam logic [9:0] F_IRW   = 10'b00_1000_0000;
    localparam logic [9:0] F_PCW   = 10'b00_0100_0000;
    localparam logic [9:0] F_REGW  = 10'b00_0010_0000;
    localparam logic [9:0] F_ASRC  = 10'b00_0001_0000;
    localparam logic [9:0] F_PCSRC = 10'b00_0000_1000;
    localparam logic [9:0] F_MEMW  = 10'b00_0000_0100;
    localparam logic [9:0] F_RSRC  = 10'b00_0000_0010;
    localparam logic [9:0] F_NONE  = 10'b00_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    instr = '0;
    logic          EQ = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, IRWrite, PCWrite, RegWrite;
    logic [2:0]    ALUctrl, ImmSrc;
    logic          ALUsrc, PCsrc, MemWrite, ResultSrc, halted;
    logic [CW-1:0] instret;

    multicycle_ctrl_fsm #(.OPC_W(7), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUctrl(ALUctrl),
        .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .PCsrc(PCsrc), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [6:0] op;
        bit         eq, ir, dr;
        logic [9:0] f;
        logic [2:0] imm;
        int         cnt;
    } row_t;

    typedef struct {
        int imem, irw, dreq, memw, pcw, pcsrc, regw, rsrc, anom, cnt;
    } obs_t;

    row_t tbl[$];

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    function automatic logic [9:0] flags();
        return {imem_req, dmem_req, IRWrite, PCWrite, RegWrite,
                ALUsrc, PCsrc, MemWrite, ResultSrc, halted};
    endfunction

    function automatic row_t mk(logic [6:0] op, bit eq, bit ir, bit dr,
                                logic [9:0] f, logic [2:0] imm, int cnt);
        row_t r;
        r.op = op; r.eq = eq; r.ir = ir; r.dr = dr; r.f = f; r.imm = imm; r.cnt = cnt;
        return r;
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction with wi imem wait cycles and wd dmem wait cycles,
    // using the expected phase timing; junk randomizes inputs the FSM must ignore.
    task automatic run_instr(input logic [6:0] op, input int wi, input int wd,
                             input bit eq, input bit junk, output obs_t o);
        bit mem;
        int lat, n, ms;
        mem = (op == OP_SW) || (op == OP_LW);
        lat = (op == OP_BNE) ? 3 : (op == OP_LW) ? 5 : 4;
        n   = wi + lat + (mem ? wd : 0);
        ms  = wi + 3;
        o   = '{default: 0};
        for (int k = 0; k < n; k++) begin
            instr      = (k == wi + 1 || !junk) ? op : 7'($urandom);
            imem_ready = (k < wi) ? 1'b0 : (k == wi) ? 1'b1 : (junk ? 1'($urandom) : 1'b0);
            if (mem && k >= ms) dmem_ready = (k == ms + wd);
            else                dmem_ready = junk ? 1'($urandom) : 1'b0;
            EQ = (k == wi + 2) ? eq : (junk ? 1'($urandom) : 1'b0);
            @(negedge clk);
            o.imem  += int'(imem_req);
            o.irw   += int'(IRWrite);
            o.dreq  += int'(dmem_req);
            o.memw  += int'(MemWrite);
            o.pcw   += int'(PCWrite);
            o.pcsrc += int'(PCWrite && PCsrc);
            o.regw  += int'(RegWrite);
            o.rsrc  += int'(RegWrite && ResultSrc);
            o.anom  += int'(halted || ALUctrl != 3'b000);
            adv();
        end
        o.cnt = int'(instret);
    endtask

    task automatic chk_obs(input string nm, input obs_t o, input logic [6:0] op,
                           input int wi, input int wd, input bit eq);
        bit mem, sw;
        mem = (op == OP_SW) || (op == OP_LW);
        sw  = (op == OP_SW);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk({nm, ".imem_req"}, o.imem, wi + 1);
        chk({nm, ".IRWrite"},  o.irw, 1);
        chk({nm, ".dmem_req"}, o.dreq, mem ? wd + 1 : 0);
        chk({nm, ".MemWrite"}, o.memw, sw ? wd + 1 : 0);
        chk({nm, ".PCWrite"},  o.pcw, 1);
        chk({nm, ".PCsrc"},    o.pcsrc, (op == OP_BNE && !eq) ? 1 : 0);
        chk({nm, ".RegWrite"}, o.regw, (op == OP_ADDI || op == OP_LW) ? 1 : 0);
        chk({nm, ".ResultSrc"}, o.rsrc, (op == OP_LW) ? 1 : 0);
        chk({nm, ".anomaly"},  o.anom, 0);
        chk({nm, ".instret"},  o.cnt, exp_cnt);
    endtask

    initial begin
        obs_t o;
        logic [6:0] ops [4];
        int pre, hcnt, pcw_cnt, ireq_cnt;
        ops[0] = OP_ADDI; ops[1] = OP_BNE; ops[2] = OP_SW; ops[3] = OP_LW;

        // Cycle-by-cycle table with zero-wait memories.
        tbl.push_back(mk(OP_ADDI, 0, 1, 1, F_IREQ | F_IRW,             IMM_I, 0));
        tbl.push_back(mk(OP_ADDI, 0, 1, 1, F_NONE,                     IMM_I, 0));
        tbl.push_back(mk(OP_ADDI, 0, 1, 1, F_ASRC,                     IMM_I, 0));
        tbl.push_back(mk(OP_ADDI, 0, 1, 1, F_REGW | F_PCW,             IMM_I, 0));
        tbl.push_back(mk(OP_BNE,  0, 1, 1, F_IREQ | F_IRW,             IMM_I, 1));
        tbl.push_back(mk(OP_BNE,  0, 1, 1, F_NONE,                     IMM_I, 1));
        tbl.push_back(mk(OP_BNE,  0, 1, 1, F_PCW | F_PCSRC,            IMM_B, 1));
        tbl.push_back(mk(OP_BNE,  1, 1, 1, F_IREQ | F_IRW,             IMM_I, 2));
        tbl.push_back(mk(OP_BNE,  1, 1, 1, F_NONE,                     IMM_I, 2));
        tbl.push_back(mk(OP_BNE,  1, 1, 1, F_PCW,                      IMM_B, 2));
        tbl.push_back(mk(OP_SW,   0, 1, 1, F_IREQ | F_IRW,             IMM_I, 3));
        tbl.push_back(mk(OP_SW,   0, 1, 1, F_NONE,                     IMM_I, 3));
        tbl.push_back(mk(OP_SW,   0, 1, 1, F_ASRC,                     IMM_S, 3));
        tbl.push_back(mk(OP_SW,   0, 1, 1, F_DREQ | F_ASRC | F_MEMW | F_PCW, IMM_S, 3));
        tbl.push_back(mk(OP_LW,   0, 1, 1, F_IREQ | F_IRW,             IMM_I, 4));
        tbl.push_back(mk(OP_LW,   0, 1, 1, F_NONE,                     IMM_I, 4));
        tbl.push_back(mk(OP_LW,   0, 1, 1, F_ASRC,                     IMM_I, 4));
        tbl.push_back(mk(OP_LW,   0, 1, 1, F_DREQ | F_ASRC,            IMM_I, 4));
        tbl.push_back(mk(OP_LW,   0, 1, 1, F_REGW | F_PCW | F_RSRC,    IMM_I, 4));
        tbl.push_back(mk(7'h00,   0, 0, 0, F_IREQ,                     IMM_I, 5));

        // Reset: everything low even with memories reporting ready.
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("reset.flags", flags(), F_NONE);
        chk("reset.ImmSrc", ImmSrc, 0);
        chk("reset.ALUctrl", ALUctrl, 0);
        chk("reset.instret", instret, 0);
        adv();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            instr = tbl[i].op; EQ = tbl[i].eq;
            imem_ready = tbl[i].ir; dmem_ready = tbl[i].dr;
            @(negedge clk);
            chk($sformatf("row%0d.flags", i), flags(), tbl[i].f);
            chk($sformatf("row%0d.ImmSrc", i), ImmSrc, tbl[i].imm);
            chk($sformatf("row%0d.instret", i), instret, tbl[i].cnt);
            chk($sformatf("row%0d.ALUctrl", i), ALUctrl, 0);
            adv();
        end
        exp_cnt = 5;

        // sw with dmem stalled three cycles.
        run_instr(OP_SW, 0, 3, 1'b0, 1'b0, o);
        chk_obs("sw_stall", o, OP_SW, 0, 3, 1'b0);
        instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        chk("sw_stall.next_fetch", flags(), F_IREQ);
        adv();

        // lw with imem delayed two cycles.
        run_instr(OP_LW, 2, 0, 1'b1, 1'b0, o);
        chk_obs("lw_ifetch_wait", o, OP_LW, 2, 0, 1'b1);

        // Reset asserted while a store is waiting in MEM.
        instr = OP_SW; imem_ready = 1'b1; dmem_ready = 1'b0;
        adv(); adv(); adv();
        @(negedge clk);
        chk("rst_mem.before", {dmem_req, MemWrite}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem.drop", {dmem_req, MemWrite, PCWrite}, 3'b000);
        chk("rst_mem.instret", instret, 0);
        adv();
        rst_n = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        chk("rst_mem.refetch", flags(), F_IREQ);
        chk("rst_mem.instret_after", instret, 0);
        adv();
        exp_cnt = 0;

        // Random instruction stream; long enough to wrap the 8-bit counter.
        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            int wi, wd;
            bit eq;
            op = ops[$urandom_range(0, 3)];
            wi = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            eq = 1'($urandom);
            run_instr(op, wi, wd, eq, 1'b1, o);
            chk_obs($sformatf("rnd%0d", i), o, op, wi, wd, eq);
        end

        // Illegal opcode traps into HALT for good.
        pre = int'(instret);
        instr = 7'b1111111; imem_ready = 1'b1;
        adv();
        @(negedge clk);
        chk("halt.decode_not_yet", halted, 0);
        adv();
        hcnt = 0; pcw_cnt = 0; ireq_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            instr = OP_ADDI; imem_ready = 1'b1; dmem_ready = 1'b1; EQ = 1'($urandom);
            @(negedge clk);
            hcnt     += int'(halted);
            pcw_cnt  += int'(PCWrite);
            ireq_cnt += int'(imem_req | IRWrite | RegWrite | dmem_req);
            adv();
        end
        chk("halt.sticky", hcnt, 6);
        chk("halt.no_pcwrite", pcw_cnt, 0);
        chk("halt.quiet", ireq_cnt, 0);
        chk("halt.instret", instret, pre);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
